// File: rtl/qsys_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qsys_pio_pkg
//  Desc     : Register map and edge encodings shared by the input PIO.
//  Revision : 1.0  initial release
// ============================================================================
package qsys_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam logic [1:0] EDGE_RISING  = 2'd0;
    localparam logic [1:0] EDGE_FALLING = 2'd1;
    localparam logic [1:0] EDGE_ANY     = 2'd2;

    function automatic logic edge_hit(input logic [1:0] edge_type,
                                      input logic cur, input logic prev);
        case (edge_type)
            EDGE_RISING:  edge_hit = cur & ~prev;
            EDGE_FALLING: edge_hit = ~cur & prev;
            default:      edge_hit = cur ^ prev;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module   : pio_debounce_bit
//  Desc     : Two-flop synchroniser plus stable-count debouncer for one pin.
//  Revision : 1.0  initial release
// ============================================================================
module pio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic deb_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= {2{RESET_VAL}};
        else       sync_q <= {sync_q[0], pin_i};
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb_o = sync_q[1];
        end else begin : g_count
            localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             deb_q, deb_d;

            // A new level is accepted only after it has differed from the
            // debounced level for DEBOUNCE_CYCLES+1 consecutive samples.
            always_comb begin
                cnt_d = cnt_q;
                deb_d = deb_q;
                if (sync_q[1] == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d = sync_q[1];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    deb_q <= RESET_VAL;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign deb_o = deb_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/qsys_system_button_pio.sv
`default_nettype none
// ============================================================================
//  Module   : qsys_system_button_pio
//  Desc     : Avalon-MM input PIO with debounce, edge capture and maskable irq.
//  Revision : 1.0  initial release
// ============================================================================
module qsys_system_button_pio
    import qsys_pio_pkg::*;
#(
    parameter int         WIDTH           = 4,
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter logic [1:0] EDGE_TYPE       = 2'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Released active-low buttons idle high, so reset to 1s to avoid a false edge.
    localparam logic IDLE_LVL = (EDGE_TYPE == EDGE_FALLING);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_dly_q;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q,  cap_d;
    logic             wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (IDLE_LVL)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .pin_i (in_port[gi]),
                .deb_o (deb[gi])
            );
        end

        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        edge_pulse = '0;
        for (int i = 0; i < WIDTH; i++)
            edge_pulse[i] = edge_hit(EDGE_TYPE, deb[i], deb_dly_q[i]);
    end

    // A fresh edge overrides a simultaneous W1C on the same bit.
    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_EDGE) cap_d = cap_q & ~writedata[WIDTH-1:0];
        cap_d = cap_d | edge_pulse;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_dly_q <= {WIDTH{IDLE_LVL}};
            mask_q    <= '0;
            cap_q     <= '0;
        end else begin
            deb_dly_q <= deb;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = deb;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_qsys_system_button_pio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qsys_system_button_pio
//  Desc     : Directed self-checking bench for the button input PIO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qsys_system_button_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    qsys_system_button_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (2'd1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        in_port = 4'hF;
        reset   = 1'b1;
        tick(2);
        reset = 1'b0;
        rd(2'd0, d);
        checks++; if (d !== 32'h0000_000F) begin failures++; $display("FAIL reset_data got=%h exp=%h", d, 32'hF); end
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_edge got=%h exp=0", d); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        tick(10);
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_no_spurious got=%h exp=0", d); end
    endtask

    task automatic test_falling_edge;
        logic [31:0] d;
        in_port = 4'hE;
        tick(7);
        rd(2'd0, d);
        checks++; if (d !== 32'hE) begin failures++; $display("FAIL edge_data got=%h exp=%h", d, 32'hE); end
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL edge_early got=%h exp=0", d); end
        tick(1);
        rd(2'd3, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL edge_latency got=%h exp=1", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_masked got=%b exp=0", irq); end
        wr(2'd2, 32'h1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL unmask_irq got=%b exp=1", irq); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        in_port = 4'hC;
        tick(3);
        in_port = 4'hE;
        tick(10);
        rd(2'd0, d);
        checks++; if (d !== 32'hE) begin failures++; $display("FAIL glitch_data got=%h exp=%h", d, 32'hE); end
        rd(2'd3, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL glitch_edge got=%h exp=1", d); end
    endtask

    task automatic test_w1c;
        logic [31:0] d;
        in_port = 4'hC;
        tick(8);
        rd(2'd3, d);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL w1c_setup got=%h exp=3", d); end
        wr(2'd2, 32'hF);
        wr(2'd3, 32'h1);
        rd(2'd3, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL w1c_bit0 got=%h exp=2", d); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_hold got=%b exp=1", irq); end
        wr(2'd3, 32'h2);
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL w1c_bit1 got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_drop got=%b exp=0", irq); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        in_port = 4'h8;
        tick(7);
        wr(2'd3, 32'h4);
        rd(2'd3, d);
        checks++; if (d !== 32'h4) begin failures++; $display("FAIL set_wins got=%h exp=4", d); end
        wr(2'd3, 32'h4);
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL clear_after got=%h exp=0", d); end
    endtask

    task automatic test_reset_mid_debounce;
        logic [31:0] d;
        in_port = 4'h0;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_edge got=%h exp=0", d); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_mask got=%h exp=0", d); end
        rd(2'd0, d);
        checks++; if (d !== 32'hF) begin failures++; $display("FAIL rst_mid_data got=%h exp=%h", d, 32'hF); end
        tick(7);
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_early got=%h exp=0", d); end
        tick(1);
        rd(2'd3, d);
        checks++; if (d[3] !== 1'b1) begin failures++; $display("FAIL rst_mid_bit3 got=%h exp=8 set", d); end
        checks++; if (d !== 32'hF) begin failures++; $display("FAIL rst_mid_all got=%h exp=%h", d, 32'hF); end
        wr(2'd3, 32'hF);
        tick(20);
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_once got=%h exp=0", d); end
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'h5);
        rd(2'd0, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ro_data got=%h exp=0", d); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rsvd_read got=%h exp=0", d); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ro_mask got=%h exp=0", d); end
        address    = 2'd2;
        writedata  = 32'hF;
        chipselect = 1'b0;
        write_n    = 1'b0;
        tick(1);
        write_n   = 1'b1;
        writedata = '0;
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL nocs_mask got=%h exp=0", d); end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        test_reset;
        test_falling_edge;
        test_glitch;
        test_w1c;
        test_back_to_back;
        test_reset_mid_debounce;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
